accu_driver: RTL and testbench
==============================

ACCU_DRIVER -- requirements
Module: accu_driver

Interface
REQ-001 Parameter: WIDTH, 8, number of pattern bits per transfer (legal 1..16).
REQ-002 Parameter: GAP, 2, idle cycles between consecutive next strobes (legal 1..15).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to send data; sampled only in IDLE.
REQ-006 data  input  WIDTH  pattern to send, MSB first; captured when start is accepted.
REQ-007 acc_out  input  1  accumulator count-reached flag, fed back from the receiving accumulator.
REQ-008 in  output  1  serial pattern bit, valid while next=1.
REQ-009 next  output  1  one-cycle strobe qualifying in.
REQ-010 busy  output  1  high from the cycle after start is accepted through the done cycle.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 hits  output  4  number of acc_out rising edges seen during the current/last transfer.
REQ-013 state_display  output  3  current FSM state code.

Function
REQ-014 FSM states and codes: IDLE=000, SEND=001, GAP=010, WAIT=011, DONE=100; other codes go to IDLE next cycle.
REQ-015 All outputs are registered; no combinational path from any input to any output.
REQ-016 IDLE: start=1 -> capture data into shift register, load bit counter with WIDTH, clear hits, enter SEND; start=0 -> stay.
REQ-017 SEND (one cycle): next=1, in=current MSB of shift register; shift left by one and decrement bit counter at end of cycle.
REQ-018 From SEND: bit counter reaches 0 -> WAIT; otherwise -> GAP.
REQ-019 GAP: next=0, in=0 for exactly GAP cycles, then SEND.
REQ-020 Timing: start sampled at edge t -> bit k (k=0 is MSB) strobed in cycle t+1+k*(GAP+1).
REQ-021 WAIT: next=0, in=0 for exactly 2 cycles (covers accumulator's registered out), then DONE.
REQ-022 DONE: done=1 for one cycle, busy=1, then IDLE; busy=0 and done=0 from the following cycle.
REQ-023 start while not in IDLE (including the DONE cycle) is ignored; data changes after capture do not affect the transfer.
REQ-024 hits increments on each cycle where acc_out=1 and acc_out was 0 the previous cycle, only while busy=1.
REQ-025 hits saturates at 15; holds its value in IDLE until the next accepted start clears it.
REQ-026 in and next are 0 in every state except SEND.

Reset
REQ-027 reset=1 at an edge forces IDLE: in=0, next=0, busy=0, done=0, hits=0, state_display=000, shift register and counters cleared.
REQ-028 reset takes precedence over start and over any in-progress transfer; no further strobes are emitted after the reset edge.
REQ-029 The acc_out edge-detect history register resets to 0.

Verification
REQ-030 GAP=2, WIDTH=8, data=8'hFF, start at edge 0, accumulator model attached -> next=1 with in=1 in cycles 1,4,7,...,22; done in cycle 25; hits=2.
REQ-031 data=8'h00 -> 8 strobes all with in=0; acc_out stays 0; hits=0; done one cycle after the 2-cycle WAIT.
REQ-032 data=8'hF0 -> in=1,1,1,1,0,0,0,0; one acc_out rising edge; hits=1.
REQ-033 start pulsed again during GAP and in the DONE cycle -> ignored; exactly 8 strobes; busy falls after done; new start in IDLE is accepted.
REQ-034 reset asserted at the 4th strobe -> next cycle: IDLE, busy=0, hits=0, no further next strobes, no done pulse.
REQ-035 acc_out held high from an external driver for 20 cycles -> hits increments once; 16 separate rising edges -> hits=15 (saturated).

Source files
------------

// File: rtl/accu_driver.sv
// Serial pattern driver for a counting accumulator. A captured WIDTH-bit word
// is strobed out MSB first (one bit per `next` pulse, GAP idle cycles apart).
// After the last bit the FSM waits two cycles so the accumulator's registered
// flag can land. It then pulses `done` for one cycle. Rising edges of the
// accumulator's `acc_out` flag are counted into a saturating `hits` counter
// while the driver is busy.
//
// Handshake: `start` is a request that is honoured only when the FSM sits in
// IDLE. There is no ready output; the caller watches `busy`, which rises the
// cycle after acceptance and falls the cycle after `done`. `in` is
// meaningful only in cycles where `next` is 1.
module accu_driver #(
    parameter int WIDTH = 8,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic             acc_out,
    output logic             in,
    output logic             next,
    output logic             busy,
    output logic             done,
    output logic [3:0]       hits,
    output logic [2:0]       state_display
);

    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_SEND = 3'b001,
        S_GAP  = 3'b010,
        S_WAIT = 3'b011,
        S_DONE = 3'b100
    } state_e;

    localparam logic [4:0] BITS_INIT = 5'(WIDTH);
    localparam logic [3:0] GAP_LOAD  = 4'(GAP - 1);
    localparam logic [3:0] WAIT_LOAD = 4'd1;
    localparam logic [3:0] HITS_MAX  = 4'd15;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [4:0]       bits_q, bits_d;
    logic [3:0]       wait_q, wait_d;
    logic             clr_hits;

    logic             in_q, next_q, busy_q, done_q;
    logic [3:0]       hits_q;
    logic             acc_prev_q;

    // Next-state logic: sequencing of send/gap/wait/done and datapath updates.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bits_d   = bits_q;
        wait_d   = wait_q;
        clr_hits = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shift_d  = data;
                    bits_d   = BITS_INIT;
                    clr_hits = 1'b1;
                    state_d  = S_SEND;
                end
            end
            S_SEND: begin
                shift_d = shift_q << 1;
                bits_d  = bits_q - 5'd1;
                if (bits_d == 5'd0) begin
                    state_d = S_WAIT;
                    wait_d  = WAIT_LOAD;
                end else begin
                    state_d = S_GAP;
                    wait_d  = GAP_LOAD;
                end
            end
            S_GAP: begin
                if (wait_q == 4'd0) state_d = S_SEND;
                else                wait_d  = wait_q - 4'd1;
            end
            S_WAIT: begin
                if (wait_q == 4'd0) state_d = S_DONE;
                else                wait_d  = wait_q - 4'd1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            bits_q  <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bits_q  <= bits_d;
            wait_q  <= wait_d;
        end
    end

    // Output registers, decoded from the upcoming state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_q   <= 1'b0;
            next_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            next_q <= (state_d == S_SEND);
            in_q   <= (state_d == S_SEND) & shift_d[WIDTH-1];
            busy_q <= (state_d != S_IDLE);
            done_q <= (state_d == S_DONE);
        end
    end

    // Saturating count of acc_out rising edges seen while busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_prev_q <= 1'b0;
            hits_q     <= 4'd0;
        end else begin
            acc_prev_q <= acc_out;
            if (clr_hits) begin
                hits_q <= 4'd0;
            end else if (busy_q && acc_out && !acc_prev_q && (hits_q != HITS_MAX)) begin
                hits_q <= hits_q + 4'd1;
            end
        end
    end

    assign in            = in_q;
    assign next          = next_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign hits          = hits_q;
    assign state_display = state_q;

endmodule

// File: tb/tb_accu_driver.sv
// Bench for accu_driver: main instance (WIDTH=8, GAP=2) with an attached
// accumulator model (flag after every 4th one-bit), plus a GAP=4 instance
// whose longer busy window fits 17 externally driven acc_out pulses.
module tb_accu_driver;

  localparam int WIDTH = 8;
  localparam int GAP   = 2;
  localparam int GAP2  = 4;
  localparam int W     = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             start, start2;
  logic [WIDTH-1:0] data, data2;
  logic             acc_out, acc2;
  logic             ser_in, nxt, busy, done;
  logic [3:0]       hits;
  logic [2:0]       st;
  logic             ser_in2, nxt2, busy2, done2;
  logic [3:0]       hits2;
  logic [2:0]       st2;

  // accumulator model and external override
  logic             model_out;
  logic [1:0]       acc_cnt;
  logic             acc_clr;
  logic             ext_mode, ext_val;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  // expected strobes: {cycle, bit}
  logic [W-1:0] exp_q[$];

  assign acc_out = ext_mode ? ext_val : model_out;

  accu_driver #(.WIDTH(WIDTH), .GAP(GAP)) u_dut (
    .clk(clk), .reset(reset), .start(start), .data(data), .acc_out(acc_out),
    .in(ser_in), .next(nxt), .busy(busy), .done(done), .hits(hits),
    .state_display(st)
  );

  accu_driver #(.WIDTH(WIDTH), .GAP(GAP2)) u_dut_sat (
    .clk(clk), .reset(reset), .start(start2), .data(data2), .acc_out(acc2),
    .in(ser_in2), .next(nxt2), .busy(busy2), .done(done2), .hits(hits2),
    .state_display(st2)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // receiving accumulator: flag one cycle after every 4th one-bit
  always @(posedge clk) begin
    if (reset || acc_clr) begin
      acc_cnt   <= 2'd0;
      model_out <= 1'b0;
    end else if (nxt && ser_in) begin
      if (acc_cnt == 2'd3) begin
        acc_cnt   <= 2'd0;
        model_out <= 1'b1;
      end else begin
        acc_cnt   <= acc_cnt + 2'd1;
        model_out <= 1'b0;
      end
    end else begin
      model_out <= 1'b0;
    end
  end

  task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // scoreboard: every strobe pops one expected {cycle, bit}
  always @(negedge clk) begin
    if (nxt === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_next", 1, 0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check_val("strobe_in", W'(ser_in), W'(e[0]));
        check_val("strobe_cycle", W'(cyc), W'(e[W-1:1]));
      end
    end
  end

  // driver: request a transfer at the next edge; returns at negedge of cycle s
  task automatic start_xfer(input logic [WIDTH-1:0] d, output int s);
    start   = 1'b1;
    data    = d;
    acc_clr = 1'b1;
    @(posedge clk); #1;
    s       = cyc;
    start   = 1'b0;
    acc_clr = 1'b0;
    data    = ~d;  // must not disturb the captured word
    for (int k = 0; k < WIDTH; k++)
      exp_q.push_back({31'(s + k * (GAP + 1)), d[WIDTH-1-k]});
    @(negedge clk);
    check_val("busy_after_accept", W'(busy), 1);
    check_val("state_send", W'(st), 1);
  endtask

  // wait for done; optionally pulse start in the done cycle
  task automatic wait_done(input int exp_c, input int exp_hits, input bit poke);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      if (done === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      check_val("done_timeout", 0, 1);
    end else begin
      check_val("done_cycle", W'(cyc), W'(exp_c));
      check_val("busy_in_done", W'(busy), 1);
      check_val("hits", W'(hits), W'(exp_hits));
      check_val("strobes_left", W'(exp_q.size()), 0);
      if (poke) begin
        start = 1'b1;
        data  = 8'h5A;
      end
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check_val("done_low_after", W'(done), 0);
      check_val("busy_low_after", W'(busy), 0);
      check_val("state_idle_after", W'(st), 0);
      check_val("hits_hold", W'(hits), W'(exp_hits));
    end
  endtask

  initial begin
    int s, s2, n_next, n_done;
    logic [WIDTH-1:0] d;
    bit hit;

    // reset, with start held high to show reset wins
    reset = 1'b1; start = 1'b1; data = 8'hFF; start2 = 1'b0; data2 = '0; acc2 = 1'b0;
    acc_clr = 1'b0; ext_mode = 1'b0; ext_val = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_state", W'(st), 0);
    check_val("rst_busy", W'(busy), 0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check_val("rst_in", W'(ser_in), 0);
    check_val("rst_next", W'(nxt), 0);
    check_val("rst_done", W'(done), 0);
    check_val("rst_hits", W'(hits), 0);

    // all ones: 8 strobes, done 24 cycles after first strobe, two flags
    start_xfer(8'hFF, s);
    wait_done(s + 24, 2, 1'b0);
    // all zeros
    start_xfer(8'h00, s);
    wait_done(s + 24, 0, 1'b0);
    // upper nibble ones: one flag
    start_xfer(8'hF0, s);
    wait_done(s + 24, 1, 1'b0);

    // start during GAP and in DONE cycle must be ignored
    start_xfer(8'hA5, s);
    start = 1'b1; data = 8'h3C;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_val("gap_state", W'(st), 2);
    wait_done(s + 24, 1, 1'b1);
    repeat (10) @(negedge clk);
    check_val("idle_after_poke", W'(st), 0);

    // random words
    for (int r = 0; r < 3; r++) begin
      d = WIDTH'($urandom_range(0, 255));
      start_xfer(d, s);
      wait_done(s + 24, $countones(d) / 4, 1'b0);
    end

    // reset during the 4th strobe
    start_xfer(8'hFF, s);
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (cyc == s + 3 * (GAP + 1)) hit = 1'b1;
      else @(negedge clk);
    end
    check_val("fourth_strobe_next", W'(nxt), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_val("mid_rst_state", W'(st), 0);
    check_val("mid_rst_busy", W'(busy), 0);
    check_val("mid_rst_hits", W'(hits), 0);
    n_next = 0; n_done = 0;
    for (int i = 0; i < 30; i++) begin
      if (nxt === 1'b1) n_next++;
      if (done === 1'b1) n_done++;
      @(negedge clk);
    end
    check_val("post_rst_strobes", W'(n_next), 0);
    check_val("post_rst_done", W'(n_done), 0);

    // acc_out held high for 20 cycles -> one hit
    ext_mode = 1'b1;
    start_xfer(8'h00, s);
    ext_val = 1'b1;
    repeat (20) @(negedge clk);
    ext_val = 1'b0;
    wait_done(s + 24, 1, 1'b0);
    ext_mode = 1'b0;

    // 17 separate rising edges on the GAP=4 instance -> saturates at 15
    start2 = 1'b1; data2 = 8'h00;
    @(posedge clk); #1;
    s2 = cyc;
    start2 = 1'b0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk); acc2 = 1'b1;
      @(negedge clk); acc2 = 1'b0;
    end
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (done2 === 1'b1) hit = 1'b1;
      else @(negedge clk);
    end
    check_val("sat_done_cycle", hit ? W'(cyc) : 0, W'(s2 + 7 * (GAP2 + 1) + 3));
    check_val("sat_hits", W'(hits2), 15);

    repeat (3) @(negedge clk);
    check_val("final_queue_empty", W'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // hard time limit
  initial begin
    #200000;
    check_val("global_timeout", 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
